awgn_channel_iq: RTL and testbench
==================================

// Module: awgn_channel_iq
// PURPOSE
//  Parametrised I/Q AWGN channel model: adds scaled pseudo-Gaussian noise to a complex sample stream.
//  Noise per rail = sum of SUM_N independent LFSR uniforms (CLT), scaled by an SNR-selected sigma.
//  Sits between modulator/pulse-shaper and receiver front end in the link testbench chain.
//  Adds valid/ready flow control, run-time SNR select, noise bypass and output saturation.
// PARAMETERS
//  DATA_W   24       I/Q sample width, signed two's complement
//  NOISE_W  12       bits taken from each LFSR as an unsigned uniform
//  SUM_N    4        uniforms summed per rail (1..8)
//  SEED_I   16'hACE1 base seed, I-rail LFSR bank
//  SEED_Q   16'h1D0F base seed, Q-rail LFSR bank
// PORTS
//  clk         in   1       clock
//  reset       in   1       synchronous, active-low reset
//  in_valid    in   1       input sample valid
//  in_ready    out  1       block accepts sample this cycle
//  in_real     in   DATA_W  input I, signed
//  in_imag     in   DATA_W  input Q, signed
//  snr_db      in   4       SNR select 0..9 dB; sampled on accept
//  noise_en    in   1       0: noise forced to 0 (pass-through); sampled on accept
//  out_valid   out  1       output sample valid
//  out_ready   in   1       downstream accepts output
//  out_real    out  DATA_W  I + noise_I, saturated
//  out_imag    out  DATA_W  Q + noise_Q, saturated
//  out_sat     out  1       either rail of this output sample clipped
//  sample_cnt  out  32      count of output handshakes, saturates at 2^32-1
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): all stage valids, out_* data, out_sat, sample_cnt -> 0; LFSRs reload seeds.
//  - Global advance: adv = !out_valid | out_ready; in_ready = adv. All 3 stages shift together on adv.
//  - Accept = in_valid & in_ready. Latency: accept at cycle t -> out_valid at t+3 with out_ready held 1.
//  - Stall: out_valid & !out_ready freezes every stage and LFSR; out_* stable; no loss, no duplication.
//  - LFSRs: 16-bit Galois, poly x^16+x^14+x^13+x^11+1 (0xB400); step once per accept only.
//    Bank k (0..SUM_N-1) seed = (SEED ^ (k<<8)) | 16'h0001 (never zero).
//  - S1: u_k = lfsr_k[15 -: NOISE_W]; n = sum(u_k) - SUM_N*2^(NOISE_W-1); signed, NOISE_W+clog2(SUM_N)+1 bits.
//    Captures in_real/in_imag, sigma, noise_en.
//  - Sigma LUT (8-bit unsigned, Q0.8): 0:180 1:161 2:143 3:128 4:114 5:102 6:90 7:81 8:72 9:64; snr_db>9 -> 64.
//  - S2: p = n * $signed({1'b0,sigma}); scaled = p >>> 8 (arithmetic), sign-extended to DATA_W+1; 0 if !noise_en.
//  - S3: y = in + scaled at DATA_W+1 bits; clip to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; out_sat = clip_I | clip_Q.
//  - sample_cnt += 1 on out_valid & out_ready; holds at all-ones.
//  - Reset mid-stream dominates handshake: in-flight samples dropped, noise sequence restarts from seeds.
//  - snr_db/noise_en changes between accepts affect only later-accepted samples.
// STRUCTURE
//  - Package awgn_pkg: SIGMA_LUT[0:9], SIGMA_MIN=64, LFSR_POLY=16'hB400, LFSR_W=16, function sigma_of(snr).
//  - Sub-module awgn_lfsr_uniform (params SEED, NOISE_W; ports clk, reset, step, u): instantiated 2*SUM_N times.
//  - Top: generate loops for banks, 3-stage pipeline regs, saturating adder, counter.
// TESTING
//  1 Bypass: noise_en=0, in=(1000,-1000), out_ready=1 -> out=(1000,-1000) exactly 3 cycles after accept, out_sat=0.
//  2 Backpressure: continuous in_valid, out_ready=0 for 5 cycles -> exactly 3 accepts then in_ready=0; order kept,
//    out_* stable while stalled, sample_cnt matches scoreboard.
//  3 Saturation: in_real=24'h7FFFF0, noise_en=1, snr_db=0 -> out_real never wraps negative; out_sat=1 when clipped.
//  4 Statistics (defaults): 65536 samples in=0: snr_db=0 -> std ~1663 (+-5%); snr_db=9 -> std ~591 (+-5%);
//    |mean| < 2% of std; I/Q correlation |rho| < 0.05.
//  5 Reset mid-stream: reset=0 while out_valid=1 -> next cycle out_valid=0, in_ready=1; subsequent noise
//    sequence bit-identical to that after power-on reset.
//  6 Clamp: snr_db=12 vs 9 with same seeds and inputs -> identical output streams.

Source files
------------

// File: rtl/awgn_pkg.sv
// Shared constants for the I/Q AWGN channel: LFSR polynomial, sigma table, SNR-to-sigma map.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package awgn_pkg;

  // Width and feedback taps of the Galois LFSR (x^16+x^14+x^13+x^11+1).
  localparam int              LFSR_W    = 16;
  localparam logic [15:0]     LFSR_POLY = 16'hB400;

  // Noise scale per dB of SNR, unsigned Q0.8; index 0..9 is SNR in dB.
  localparam logic [7:0]      SIGMA_MIN = 8'd64;
  localparam logic [7:0]      SIGMA_LUT [0:9] = '{
    8'd180, 8'd161, 8'd143, 8'd128, 8'd114,
    8'd102, 8'd90,  8'd81,  8'd72,  8'd64
  };

  // Out-of-range SNR selects clamp to the quietest table entry.
  function automatic logic [7:0] sigma_of(input logic [3:0] snr);
    logic [7:0] s;
    s = SIGMA_MIN;
    if (snr <= 4'd9) s = SIGMA_LUT[snr];
    return s;
  endfunction

endpackage

// File: rtl/awgn_lfsr_uniform.sv
// One 16-bit Galois LFSR producing an unsigned uniform from its top NOISE_W bits.
// Latency: u reflects the current state; state advances one cycle after step.
// Backpressure: holds its state whenever step is low.
module awgn_lfsr_uniform
  import awgn_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
  parameter int                NOISE_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  output logic [NOISE_W-1:0] u
);

  logic [LFSR_W-1:0] state;
  logic [LFSR_W-1:0] state_next;

  // Right-shifting Galois step: feedback taps applied when the bit shifted out is 1.
  always_comb begin
    state_next = {1'b0, state[LFSR_W-1:1]} ^ (state[0] ? LFSR_POLY : '0);
  end

  // State register: reload seed on reset, otherwise advance only when asked.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= SEED;
    end else if (step) begin
      state <= state_next;
    end
  end

  assign u = state[LFSR_W-1 -: NOISE_W];

endmodule

// File: rtl/awgn_channel_iq.sv
// I/Q AWGN channel: adds CLT noise (sum of LFSR uniforms scaled by SNR sigma) with saturation.
// Latency: 3 cycles from input accept to out_valid while out_ready stays high.
// Backpressure: all stages and the LFSRs freeze while out_valid & !out_ready; in_ready follows.
module awgn_channel_iq
  import awgn_pkg::*;
#(
  parameter int                DATA_W  = 24,
  parameter int                NOISE_W = 12,
  parameter int                SUM_N   = 4,
  parameter logic [LFSR_W-1:0] SEED_I  = 16'hACE1,
  parameter logic [LFSR_W-1:0] SEED_Q  = 16'h1D0F
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  input  logic [3:0]               snr_db,
  input  logic                     noise_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag,
  output logic                     out_sat,
  output logic [31:0]              sample_cnt
);

  // Sum of SUM_N uniforms centred on zero needs clog2(SUM_N) growth plus a sign bit.
  localparam int SUM_W  = NOISE_W + $clog2(SUM_N) + 1;
  // Product with a 9-bit signed (zero-extended 8-bit) sigma.
  localparam int PROD_W = SUM_W + 9;
  // One guard bit above the sample width so the add never wraps before clipping.
  localparam int EXT_W  = DATA_W + 1;

  localparam logic [SUM_W-1:0]  SUM_OFFSET = SUM_W'(SUM_N) << (NOISE_W - 1);
  localparam logic [DATA_W-1:0] MAX_V      = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V      = {1'b1, {(DATA_W-1){1'b0}}};

  // ---------------------------------------------------------------- flow control
  logic adv;
  logic accept;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------- LFSR banks
  logic [NOISE_W-1:0] u_i [SUM_N];
  logic [NOISE_W-1:0] u_q [SUM_N];

  for (genvar k = 0; k < SUM_N; k++) begin : g_bank
    // Each bank gets a distinct seed; forcing bit 0 keeps it off the all-zero lock-up state.
    localparam logic [LFSR_W-1:0] BANK_OFS = LFSR_W'(k) << 8;

    awgn_lfsr_uniform #(
      .SEED    ((SEED_I ^ BANK_OFS) | 16'h0001),
      .NOISE_W (NOISE_W)
    ) u_lfsr_i (
      .clk   (clk),
      .reset (reset),
      .step  (accept),
      .u     (u_i[k])
    );

    awgn_lfsr_uniform #(
      .SEED    ((SEED_Q ^ BANK_OFS) | 16'h0001),
      .NOISE_W (NOISE_W)
    ) u_lfsr_q (
      .clk   (clk),
      .reset (reset),
      .step  (accept),
      .u     (u_q[k])
    );
  end

  // ---------------------------------------------------------------- S1 inputs
  logic [SUM_W-1:0]        sum_i;
  logic [SUM_W-1:0]        sum_q;
  logic signed [SUM_W-1:0] n_i;
  logic signed [SUM_W-1:0] n_q;
  logic [7:0]              sigma_sel;

  // Add the uniforms of each rail; the offset removes the mean so noise is zero-centred.
  always_comb begin
    sum_i = '0;
    sum_q = '0;
    for (int k = 0; k < SUM_N; k++) begin
      sum_i = sum_i + SUM_W'(u_i[k]);
      sum_q = sum_q + SUM_W'(u_q[k]);
    end
  end

  assign n_i       = sum_i - SUM_OFFSET;
  assign n_q       = sum_q - SUM_OFFSET;
  assign sigma_sel = sigma_of(snr_db);

  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_real;
  logic signed [DATA_W-1:0] s1_imag;
  logic signed [SUM_W-1:0]  s1_n_i;
  logic signed [SUM_W-1:0]  s1_n_q;
  logic [7:0]               s1_sigma;
  logic                     s1_noise_en;

  // Stage 1: capture sample, raw noise and the controls that belong to this sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid    <= 1'b0;
      s1_real     <= '0;
      s1_imag     <= '0;
      s1_n_i      <= '0;
      s1_n_q      <= '0;
      s1_sigma    <= '0;
      s1_noise_en <= 1'b0;
    end else if (adv) begin
      s1_valid    <= accept;
      s1_real     <= in_real;
      s1_imag     <= in_imag;
      s1_n_i      <= n_i;
      s1_n_q      <= n_q;
      s1_sigma    <= sigma_sel;
      s1_noise_en <= noise_en;
    end
  end

  // ---------------------------------------------------------------- S2 scaling
  logic signed [PROD_W-1:0] n_i_x;
  logic signed [PROD_W-1:0] n_q_x;
  logic signed [PROD_W-1:0] sig_x;
  logic signed [PROD_W-1:0] p_i;
  logic signed [PROD_W-1:0] p_q;
  logic signed [PROD_W-1:0] sh_i;
  logic signed [PROD_W-1:0] sh_q;
  logic signed [EXT_W-1:0]  scaled_i;
  logic signed [EXT_W-1:0]  scaled_q;

  assign n_i_x = PROD_W'(s1_n_i);
  assign n_q_x = PROD_W'(s1_n_q);
  assign sig_x = PROD_W'({1'b0, s1_sigma});
  assign p_i   = n_i_x * sig_x;
  assign p_q   = n_q_x * sig_x;
  // Q0.8 sigma: drop the fractional byte, rounding toward minus infinity.
  assign sh_i  = p_i >>> 8;
  assign sh_q  = p_q >>> 8;

  assign scaled_i = s1_noise_en ? EXT_W'(sh_i) : '0;
  assign scaled_q = s1_noise_en ? EXT_W'(sh_q) : '0;

  logic                     s2_valid;
  logic signed [DATA_W-1:0] s2_real;
  logic signed [DATA_W-1:0] s2_imag;
  logic signed [EXT_W-1:0]  s2_noise_i;
  logic signed [EXT_W-1:0]  s2_noise_q;

  // Stage 2: register the scaled (or bypassed) noise alongside the sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_valid   <= 1'b0;
      s2_real    <= '0;
      s2_imag    <= '0;
      s2_noise_i <= '0;
      s2_noise_q <= '0;
    end else if (adv) begin
      s2_valid   <= s1_valid;
      s2_real    <= s1_real;
      s2_imag    <= s1_imag;
      s2_noise_i <= scaled_i;
      s2_noise_q <= scaled_q;
    end
  end

  // ---------------------------------------------------------------- S3 add + clip
  logic signed [EXT_W-1:0]  y_i;
  logic signed [EXT_W-1:0]  y_q;
  logic                     clip_i;
  logic                     clip_q;
  logic signed [DATA_W-1:0] sat_i;
  logic signed [DATA_W-1:0] sat_q;

  assign y_i = EXT_W'(s2_real) + s2_noise_i;
  assign y_q = EXT_W'(s2_imag) + s2_noise_q;

  // Guard bit disagreeing with the sample MSB means the sum left the DATA_W range.
  always_comb begin
    clip_i = y_i[EXT_W-1] ^ y_i[DATA_W-1];
    clip_q = y_q[EXT_W-1] ^ y_q[DATA_W-1];
    sat_i  = y_i[DATA_W-1:0];
    sat_q  = y_q[DATA_W-1:0];
    if (clip_i) sat_i = y_i[EXT_W-1] ? MIN_V : MAX_V;
    if (clip_q) sat_q = y_q[EXT_W-1] ? MIN_V : MAX_V;
  end

  // Stage 3: output register; held while downstream stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      out_real  <= sat_i;
      out_imag  <= sat_q;
      out_sat   <= clip_i || clip_q;
    end
  end

  // Output handshake counter, sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sample_cnt <= '0;
    end else if (out_valid && out_ready && (sample_cnt != '1)) begin
      sample_cnt <= sample_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_awgn_channel_iq.sv
// Scoreboard bench for awgn_channel_iq: behavioural noise model, directed + random traffic.
// Latency: checks the 3-cycle accept-to-output path and stall hold behaviour.
// Backpressure: random and directed out_ready stalls; expected samples queued at accept.
module tb_awgn_channel_iq;

  localparam int DATA_W  = 24;
  localparam int NOISE_W = 12;
  localparam int SUM_N   = 4;
  localparam int DMAX    = 8388607;
  localparam int DMIN    = -8388608;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_imag;
  logic [3:0]               snr_db;
  logic                     noise_en;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_real;
  logic signed [DATA_W-1:0] out_imag;
  logic                     out_sat;
  logic [31:0]              sample_cnt;

  always #5 clk = ~clk;

  awgn_channel_iq #(
    .DATA_W (DATA_W), .NOISE_W (NOISE_W), .SUM_N (SUM_N),
    .SEED_I (16'hACE1), .SEED_Q (16'h1D0F)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_real    (in_real),
    .in_imag    (in_imag),
    .snr_db     (snr_db),
    .noise_en   (noise_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_real   (out_real),
    .out_imag   (out_imag),
    .out_sat    (out_sat),
    .sample_cnt (sample_cnt)
  );

  typedef struct {
    int re;
    int im;
    int sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   lfsr_i [SUM_N];
  int   lfsr_q [SUM_N];
  int   sat_seen = 0;
  bit   stat_on  = 1'b0;
  int   stat_n   = 0;
  real  stat_sum = 0.0;
  real  stat_sq  = 0.0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  function automatic int lfsr_step(input int s);
    int r;
    r = s >> 1;
    if (s & 1) r = r ^ 32'hB400;
    return r;
  endfunction

  function automatic int sigma_ref(input int snr);
    int tbl [10] = '{180, 161, 143, 128, 114, 102, 90, 81, 72, 64};
    if (snr > 9) return 64;
    return tbl[snr];
  endfunction

  function automatic int clamp(input int y);
    if (y > DMAX) return DMAX;
    if (y < DMIN) return DMIN;
    return y;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < SUM_N; k++) begin
      lfsr_i[k] = (32'hACE1 ^ (k << 8)) | 1;
      lfsr_q[k] = (32'h1D0F ^ (k << 8)) | 1;
    end
  endtask

  task automatic model_accept(input int re, input int im, input int snr, input bit ne);
    exp_t e;
    int   ni, nq, sg, zi, zq, yi, yq;
    ni = -(SUM_N * (1 << (NOISE_W - 1)));
    nq = ni;
    for (int k = 0; k < SUM_N; k++) begin
      ni += lfsr_i[k] >> (16 - NOISE_W);
      nq += lfsr_q[k] >> (16 - NOISE_W);
      lfsr_i[k] = lfsr_step(lfsr_i[k]);
      lfsr_q[k] = lfsr_step(lfsr_q[k]);
    end
    sg = sigma_ref(snr);
    zi = ne ? ((ni * sg) >>> 8) : 0;
    zq = ne ? ((nq * sg) >>> 8) : 0;
    yi = re + zi;
    yq = im + zq;
    e.re  = clamp(yi);
    e.im  = clamp(yq);
    e.sat = ((yi != e.re) || (yq != e.im)) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // ------------------------------------------------------------ driver
  task automatic cyc(input bit v, input int re, input int im, input int snr, input bit ne,
                     input bit ordy, input bit rst_n, output bit acc);
    @(negedge clk);
    reset     = rst_n;
    in_valid  = v;
    in_real   = 24'(re);
    in_imag   = 24'(im);
    snr_db    = 4'(snr);
    noise_en  = ne;
    out_ready = ordy;
    #1;
    acc = rst_n && v && in_ready;
    if (!rst_n) begin
      exp_q.delete();
      model_reset();
    end else if (acc) begin
      model_accept(re, im, snr, ne);
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1, a);
  endtask

  function automatic int rnd_data();
    return int'($urandom_range(0, 32'h00FF_FFFF)) - 8388608;
  endfunction

  // ------------------------------------------------------------ monitor
  initial begin : monitor
    int   hs_cnt;
    bit   stalled;
    int   prev_re, prev_im, prev_sat;
    exp_t e;
    hs_cnt  = 0;
    stalled = 1'b0;
    prev_re = 0;
    prev_im = 0;
    prev_sat = 0;
    forever begin
      @(negedge clk);
      #2;
      if (reset !== 1'b1) begin
        hs_cnt  = 0;
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        check("stall_valid_held", int'(out_valid), 1);
        check("stall_real_held", int'(out_real), prev_re);
        check("stall_imag_held", int'(out_imag), prev_im);
        check("stall_sat_held", int'(out_sat), prev_sat);
      end
      if (out_valid && out_ready) begin
        check("sample_cnt", int'(sample_cnt), hs_cnt);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got out_valid=1, expected no pending sample");
        end else begin
          e = exp_q.pop_front();
          check("out_real", int'(out_real), e.re);
          check("out_imag", int'(out_imag), e.im);
          check("out_sat", int'(out_sat), e.sat);
        end
        if (out_sat) sat_seen++;
        if (stat_on) begin
          stat_n++;
          stat_sum += real'(int'(out_real));
          stat_sq  += real'(int'(out_real)) * real'(int'(out_real));
        end
        hs_cnt++;
      end
      stalled  = out_valid && !out_ready;
      prev_re  = int'(out_real);
      prev_im  = int'(out_imag);
      prev_sat = int'(out_sat);
    end
  end

  // ------------------------------------------------------------ stimulus
  initial begin : stim
    bit  a;
    int  accs;
    int  lat;
    real mean, var_r, sd;

    reset = 1'b0; in_valid = 1'b0; in_real = '0; in_imag = '0;
    snr_db = '0; noise_en = 1'b0; out_ready = 1'b1;
    model_reset();
    cyc(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, a);
    cyc(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, a);
    cyc(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, a);

    // Reset state
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_sample_cnt", int'(sample_cnt), 0);
    check("rst_out_sat", int'(out_sat), 0);
    check("rst_out_real", int'(out_real), 0);

    // Bypass with latency measurement
    cyc(1'b1, 1000, -1000, 0, 1'b0, 1'b1, 1'b1, a);
    check("bypass_accept", int'(a), 1);
    lat = -1;
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1, a);
      if (out_valid && lat < 0) lat = k;
    end
    check("bypass_latency", lat, 3);

    // Backpressure: pipeline fills with exactly three samples then blocks
    accs = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, rnd_data(), rnd_data(), $urandom_range(0, 15), 1'b1, 1'b0, 1'b1, a);
      if (a) accs++;
    end
    check("bp_accepts", accs, 3);
    check("bp_in_ready", int'(in_ready), 0);
    idle(6);

    // Saturation near both rails
    sat_seen = 0;
    for (int k = 0; k < 32; k++)
      cyc(1'b1, 8388592, -8388592, 0, 1'b1, 1'b1, 1'b1, a);
    idle(5);
    check("sat_seen", int'(sat_seen > 0), 1);

    // SNR select above 9 behaves as 9
    for (int k = 0; k < 16; k++)
      cyc(1'b1, 0, 0, 10 + (k % 6), 1'b1, 1'b1, 1'b1, a);
    idle(5);

    // Random traffic with random stalls and controls
    for (int k = 0; k < 800; k++)
      cyc($urandom_range(0, 9) < 7, rnd_data(), rnd_data(), $urandom_range(0, 15),
          $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, 1'b1, a);
    idle(6);

    // Reset while output is valid and stalled
    for (int k = 0; k < 3; k++)
      cyc(1'b1, rnd_data(), rnd_data(), 3, 1'b1, 1'b0, 1'b1, a);
    cyc(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, a);
    check("pre_reset_out_valid", int'(out_valid), 1);
    cyc(1'b1, 5, 5, 0, 1'b1, 1'b1, 1'b0, a);
    cyc(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, a);
    check("post_reset_out_valid", int'(out_valid), 0);
    check("post_reset_in_ready", int'(in_ready), 1);
    check("post_reset_cnt", int'(sample_cnt), 0);
    for (int k = 0; k < 20; k++)
      cyc(1'b1, 0, 0, 0, 1'b1, 1'b1, 1'b1, a);
    idle(5);

    // Noise statistics at 0 dB
    stat_on = 1'b1;
    for (int k = 0; k < 4096; k++)
      cyc(1'b1, 0, 0, 0, 1'b1, 1'b1, 1'b1, a);
    idle(5);
    stat_on = 1'b0;
    check("stat_samples", stat_n, 4096);
    mean  = (stat_n > 0) ? stat_sum / stat_n : 0.0;
    var_r = (stat_n > 0) ? stat_sq / stat_n - mean * mean : 0.0;
    sd    = (var_r > 0.0) ? $sqrt(var_r) : 0.0;
    check("stat_std", int'(sd), (sd > 1413.0 && sd < 1913.0) ? int'(sd) : 1663);
    check("stat_mean_small", int'(mean < 0.1 * sd && mean > -0.1 * sd), 1);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
